// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with saturating direction counters,
// a global flush, and saturating performance counters.
// Optional macro BRANCH_PREDICTOR_GSHARE_EN: direction counters are indexed by idx ^ GHR.
module branch_predictor #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned PERF_W   = 32,
  localparam int unsigned IDX     = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_next_pc,
  output logic [IDX-1:0]    pred_ghr,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_is_branch,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_mispredict,
  input  logic [IDX-1:0]    upd_ghr,
  input  logic              flush_all,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [ENTRIES-1:0]  valid;
  logic [TAG_BITS-1:0] tags    [ENTRIES];
  logic [XLEN-1:0]     targets [ENTRIES];
  logic [CTR_BITS-1:0] ctrs    [ENTRIES];

  logic [IDX-1:0]      lk_idx, lk_cidx, up_idx, up_cidx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic                up_hit;
  logic [CTR_BITS-1:0] ctr_next;
  logic                unused_bits;

  assign lk_idx = lookup_pc[IDX+1:2];
  assign lk_tag = lookup_pc[IDX+1+TAG_BITS:IDX+2];
  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = upd_pc[IDX+1+TAG_BITS:IDX+2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [IDX-1:0] ghr;

  // Global history: shift in resolved branch outcomes, cleared by flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= '0;
    end else if (flush_all) begin
      ghr <= '0;
    end else if (upd_valid && upd_is_branch) begin
      ghr <= IDX'({ghr, upd_taken});
    end
  end

  assign lk_cidx     = lk_idx ^ ghr;
  assign up_cidx     = up_idx ^ upd_ghr;
  assign pred_ghr    = ghr;
  assign unused_bits = ^upd_pc;
`else
  assign lk_cidx     = lk_idx;
  assign up_cidx     = up_idx;
  assign pred_ghr    = '0;
  assign unused_bits = ^{upd_pc, upd_ghr};
`endif

  // Zero-latency lookup from registered state only (no update bypass)
  always_comb begin
    pred_hit     = valid[lk_idx] && (tags[lk_idx] == lk_tag);
    pred_taken   = pred_hit && ctrs[lk_cidx][CTR_BITS-1];
    pred_next_pc = pred_taken ? targets[lk_idx] : lookup_pc + XLEN'(4);
  end

  // Training-side hit detection and saturating counter step
  always_comb begin
    up_hit   = valid[up_idx] && (tags[up_idx] == up_tag);
    ctr_next = ctrs[up_cidx];
    if (upd_taken) begin
      if (ctr_next != CTR_MAX) ctr_next = ctr_next + CTR_BITS'(1);
    end else begin
      if (ctr_next != '0) ctr_next = ctr_next - CTR_BITS'(1);
    end
  end

  // BTB storage: reset, flush (wins over update), train or allocate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tags[IDX'(i)]    <= '0;
        targets[IDX'(i)] <= '0;
        ctrs[IDX'(i)]    <= CTR_WNT;
      end
    end else if (flush_all) begin
      valid <= '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_is_branch) begin
          ctrs[up_cidx] <= ctr_next;
          if (upd_taken) targets[up_idx] <= upd_target;
        end else begin
          ctrs[up_cidx]   <= CTR_MAX;
          targets[up_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        valid[up_idx]   <= 1'b1;
        tags[up_idx]    <= up_tag;
        targets[up_idx] <= upd_target;
        ctrs[up_cidx]   <= upd_is_branch ? CTR_WT : CTR_MAX;
      end
    end
  end

  // Saturating performance counters, independent of flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (upd_valid && upd_is_branch && (perf_branches != '1))
        perf_branches <= perf_branches + PERF_W'(1);
      if (upd_valid && upd_mispredict && (perf_mispredicts != '1))
        perf_mispredicts <= perf_mispredicts + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16, TAG_BITS=8, CTR_BITS=2, PERF_W=4).
module tb_branch_predictor;

  localparam int unsigned PW = 4;

  logic          clk;
  logic          rst;
  logic [31:0]   lookup_pc;
  logic          pred_hit;
  logic          pred_taken;
  logic [31:0]   pred_next_pc;
  logic [3:0]    pred_ghr;
  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic          upd_is_branch;
  logic          upd_taken;
  logic [31:0]   upd_target;
  logic          upd_mispredict;
  logic [3:0]    upd_ghr;
  logic          flush_all;
  logic [PW-1:0] perf_branches;
  logic [PW-1:0] perf_mispredicts;

  branch_predictor #(.PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .pred_ghr(pred_ghr), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_is_branch(upd_is_branch), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .upd_ghr(upd_ghr), .flush_all(flush_all),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_upd;
    logic [31:0] pc;
    logic        br;
    logic        tk;
    logic [31:0] tgt;
    logic        hit;
    logic        taken;
    logic [31:0] nxt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_br   = 0;
  int   exp_mis  = 0;
  int   sat_max  = (1 << PW) - 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic add_u(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt);
    vec_t v;
    v = '{is_upd: 1'b1, pc: pc, br: br, tk: tk, tgt: tgt, hit: 1'b0, taken: 1'b0, nxt: 32'h0};
    vecs.push_back(v);
  endtask

  task automatic add_l(input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] nxt);
    vec_t v;
    v = '{is_upd: 1'b0, pc: pc, br: 1'b0, tk: 1'b0, tgt: 32'h0, hit: hit, taken: tk, nxt: nxt};
    vecs.push_back(v);
  endtask

  // One update cycle; inputs are driven 1 time unit after the rising edge
  task automatic upd(input logic [31:0] pc, input logic br, input logic tk,
                     input logic [31:0] tgt, input logic mis, input logic fl);
    upd_valid = 1'b1; upd_pc = pc; upd_is_branch = br; upd_taken = tk;
    upd_target = tgt; upd_mispredict = mis; flush_all = fl;
    @(posedge clk); #1;
    upd_valid = 1'b0; flush_all = 1'b0; upd_mispredict = 1'b0;
    if (br)  exp_br  = (exp_br  == sat_max) ? sat_max : exp_br + 1;
    if (mis) exp_mis = (exp_mis == sat_max) ? sat_max : exp_mis + 1;
  endtask

  task automatic look(input string name, input logic [31:0] pc,
                      input logic hit, input logic tk, input logic [31:0] nxt);
    lookup_pc = pc; #1;
    chk({name, "_hit"}, 32'(pred_hit), 32'(hit));
    chk({name, "_taken"}, 32'(pred_taken), 32'(tk));
    chk({name, "_next"}, pred_next_pc, nxt);
  endtask

  initial begin
    rst = 1'b0; lookup_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0; upd_is_branch = 1'b0;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0; upd_ghr = '0; flush_all = 1'b0;

    // Reset state
    #3;
    chk("rst_hit", 32'(pred_hit), 32'd0);
    chk("rst_taken", 32'(pred_taken), 32'd0);
    chk("rst_next", pred_next_pc, 32'h104);
    chk("rst_ghr", 32'(pred_ghr), 32'd0);
    chk("rst_perf_br", 32'(perf_branches), 32'd0);
    chk("rst_perf_mis", 32'(perf_mispredicts), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Allocation, counter walk and saturation
    add_l(32'h100, 0, 0, 32'h104);
    add_u(32'h100, 1, 1, 32'h40);
    add_l(32'h100, 1, 1, 32'h40);
    add_u(32'h100, 1, 0, 32'h0);
    add_u(32'h100, 1, 0, 32'h0);
    add_l(32'h100, 1, 0, 32'h104);
    add_u(32'h100, 1, 1, 32'h40);
    add_u(32'h100, 1, 1, 32'h40);
    add_l(32'h100, 1, 1, 32'h40);
    add_u(32'h100, 1, 1, 32'h40);
    add_u(32'h100, 1, 1, 32'h40);
    add_u(32'h100, 1, 0, 32'h0);
    add_l(32'h100, 1, 1, 32'h40);
    add_u(32'h100, 1, 0, 32'h0);
    add_l(32'h100, 1, 0, 32'h104);
    // Aliasing on index 0
    add_l(32'h500, 0, 0, 32'h504);
    add_u(32'h500, 1, 1, 32'h80);
    add_l(32'h100, 0, 0, 32'h104);
    add_l(32'h500, 1, 1, 32'h80);
    // Unconditional allocates at max, then one not-taken step stays taken
    add_u(32'h304, 0, 1, 32'h1000);
    add_l(32'h304, 1, 1, 32'h1000);
    add_u(32'h304, 1, 0, 32'h0);
    add_l(32'h304, 1, 1, 32'h1000);
    // Not-taken miss does not allocate
    add_u(32'h308, 1, 0, 32'h0);
    add_l(32'h308, 0, 0, 32'h30C);
    // Not-taken hit keeps the old target; taken hit rewrites it
    add_u(32'h500, 1, 0, 32'h999);
    add_l(32'h500, 1, 0, 32'h504);
    add_u(32'h500, 1, 1, 32'h88);
    add_l(32'h500, 1, 1, 32'h88);
    // Fall-through wraps modulo 2^32
    add_l(32'hFFFF_FFFC, 0, 0, 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].is_upd)
        upd(vecs[i].pc, vecs[i].br, vecs[i].tk, vecs[i].tgt, 1'b0, 1'b0);
      else
        look($sformatf("vec%0d", i), vecs[i].pc, vecs[i].hit, vecs[i].taken, vecs[i].nxt);
    end
    chk("perf_br_pre_flush", 32'(perf_branches), 32'(exp_br));

    // Flush beats a simultaneous update, which still counts as a branch
    upd(32'h200, 1, 1, 32'h60, 1'b0, 1'b1);
    look("flush_200", 32'h200, 0, 0, 32'h204);
    look("flush_500", 32'h500, 0, 0, 32'h504);
    look("flush_304", 32'h304, 0, 0, 32'h308);
    chk("perf_br_flush", 32'(perf_branches), 32'(exp_br));

    // Same-cycle lookup sees the pre-update entry
    lookup_pc = 32'h704;
    upd_valid = 1'b1; upd_pc = 32'h704; upd_is_branch = 1'b1; upd_taken = 1'b1;
    upd_target = 32'h44; #1;
    chk("same_cycle_hit", 32'(pred_hit), 32'd0);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    exp_br = (exp_br == sat_max) ? sat_max : exp_br + 1;
    look("after_same_cycle", 32'h704, 1, 1, 32'h44);

    // Mispredict counter saturates at all-ones
    for (int k = 0; k < 14; k++) upd(32'h3F0, 0, 0, 32'h0, 1'b1, 1'b0);
    chk("perf_mis_14", 32'(perf_mispredicts), 32'd14);
    upd(32'h3F0, 0, 0, 32'h0, 1'b1, 1'b0);
    chk("perf_mis_15", 32'(perf_mispredicts), 32'hF);
    for (int k = 0; k < 3; k++) upd(32'h3F0, 0, 0, 32'h0, 1'b1, 1'b0);
    chk("perf_mis_sat", 32'(perf_mispredicts), 32'hF);
    chk("perf_mis_model", 32'(perf_mispredicts), 32'(exp_mis));

    // Global history after taken, taken, not-taken
    upd(32'h0, 0, 0, 32'h0, 1'b0, 1'b1);
    chk("ghr_cleared", 32'(pred_ghr), 32'd0);
    upd(32'h3F0, 1, 1, 32'h10, 1'b0, 1'b0);
    upd(32'h3F0, 1, 1, 32'h10, 1'b0, 1'b0);
    upd(32'h3F0, 1, 0, 32'h0, 1'b0, 1'b0);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    chk("ghr_tt_nt", 32'(pred_ghr), 32'h6);
`else
    chk("ghr_tt_nt", 32'(pred_ghr), 32'h0);
`endif
    chk("perf_br_final", 32'(perf_branches), 32'(exp_br));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
